// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and
// load/store (D), with a single outstanding transaction and owner-routed responses.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction outstanding; winner may be offered to memory
// WAIT  | one transaction accepted; waiting for m_rsp_valid
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    output logic                    i_rsp_valid,
    output logic [DATA_WIDTH-1:0]   i_rsp_data,

    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic                    d_write_enable,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    input  logic [DATA_WIDTH-1:0]   d_write_data,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,

    output logic                    m_req_valid,
    input  logic                    m_req_ready,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic                    m_write_enable,
    output logic [DATA_WIDTH/8-1:0] m_byte_enable,
    output logic [DATA_WIDTH-1:0]   m_write_data,
    input  logic                    m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   m_rsp_data
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {SEL_I, SEL_D} sel_t;

    state_t state, state_next;
    sel_t   owner, lock_owner, last_grant, winner;
    logic   lock;
    logic   handshake;

    // A stalled offer pins the winner so the memory sees a stable request.
    always_comb begin
        if (lock) begin
            winner = lock_owner;
        end else if (i_req_valid && d_req_valid) begin
            winner = (last_grant == SEL_I) ? SEL_D : SEL_I;
        end else if (d_req_valid) begin
            winner = SEL_D;
        end else begin
            winner = SEL_I;
        end
    end

    always_comb begin
        state_next     = state;
        m_req_valid    = 1'b0;
        handshake      = 1'b0;
        i_req_ready    = 1'b0;
        d_req_ready    = 1'b0;
        i_rsp_valid    = 1'b0;
        d_rsp_valid    = 1'b0;
        m_address      = (winner == SEL_D) ? d_address : i_address;
        m_write_enable = (winner == SEL_D) && d_write_enable;
        m_byte_enable  = (winner == SEL_D) ? d_byte_enable : '0;
        m_write_data   = (winner == SEL_D) ? d_write_data : '0;
        i_rsp_data     = m_rsp_data;
        d_rsp_data     = m_rsp_data;
        case (state)
            IDLE: begin
                m_req_valid = rst_n && (i_req_valid || d_req_valid);
                handshake   = m_req_valid && m_req_ready;
                i_req_ready = handshake && (winner == SEL_I);
                d_req_ready = handshake && (winner == SEL_D);
                if (handshake) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                i_rsp_valid = rst_n && m_rsp_valid && (owner == SEL_I);
                d_rsp_valid = rst_n && m_rsp_valid && (owner == SEL_D);
                if (m_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= SEL_I;
            lock       <= 1'b0;
            lock_owner <= SEL_I;
            last_grant <= SEL_D;
        end else begin
            state <= state_next;
            if (handshake) begin
                owner      <= winner;
                last_grant <= winner;
                lock       <= 1'b0;
            end else if (m_req_valid) begin
                lock       <= 1'b1;
                lock_owner <= winner;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table for the corner cases, then
// constrained-random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NV = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req_valid, i_req_ready, i_rsp_valid;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid, d_req_ready, d_write_enable, d_rsp_valid;
    logic [AW-1:0] d_address;
    logic [BW-1:0] d_byte_enable;
    logic [DW-1:0] d_write_data, d_rsp_data;
    logic          m_req_valid, m_req_ready, m_write_enable, m_rsp_valid;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_byte_enable;
    logic [DW-1:0] m_write_data, m_rsp_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .i_req_ready    (i_req_ready),
        .i_address      (i_address),
        .i_rsp_valid    (i_rsp_valid),
        .i_rsp_data     (i_rsp_data),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_address      (d_address),
        .d_write_enable (d_write_enable),
        .d_byte_enable  (d_byte_enable),
        .d_write_data   (d_write_data),
        .d_rsp_valid    (d_rsp_valid),
        .d_rsp_data     (d_rsp_data),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_address      (m_address),
        .m_write_enable (m_write_enable),
        .m_byte_enable  (m_byte_enable),
        .m_write_data   (m_write_data),
        .m_rsp_valid    (m_rsp_valid),
        .m_rsp_data     (m_rsp_data)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ia;
        logic          dv;
        logic [AW-1:0] da;
        logic          dwe;
        logic [BW-1:0] dbe;
        logic [DW-1:0] dwd;
        logic          mrdy;
        logic          mrv;
        logic [DW-1:0] mrd;
        logic          e_ir;
        logic          e_dr;
        logic          e_mv;
        logic [AW-1:0] e_ma;
        logic          e_mwe;
        logic [BW-1:0] e_mbe;
        logic [DW-1:0] e_mwd;
        logic          e_irv;
        logic          e_drv;
    } vec_t;

    vec_t vecs[NV];
    int   n_pass = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [AW-1:0] ia,
                         input logic dv, input logic [AW-1:0] da, input logic dwe,
                         input logic [BW-1:0] dbe, input logic [DW-1:0] dwd,
                         input logic mrdy, input logic mrv, input logic [DW-1:0] mrd);
        rst_n          = rst;
        i_req_valid    = iv;
        i_address      = ia;
        d_req_valid    = dv;
        d_address      = da;
        d_write_enable = dwe;
        d_byte_enable  = dbe;
        d_write_data   = dwd;
        m_req_ready    = mrdy;
        m_rsp_valid    = mrv;
        m_rsp_data     = mrd;
    endtask

    // Transaction-level reference state for the random phase.
    logic          mb;
    int            mown, mlast, mheld, win;
    logic          ip, dp, rr, emv, ehs, mrdy_r, mrv_r;
    logic [AW-1:0] ia_r, da_r;
    logic          dwe_r;
    logic [BW-1:0] dbe_r;
    logic [DW-1:0] dwd_r, mrd_r;

    initial begin
        vecs[0]  = '{1'b0, 1'b1,32'h10, 1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[1]  = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1,32'h55,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[2]  = '{1'b1, 1'b1,32'h10, 1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h10, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[3]  = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0};
        vecs[4]  = '{1'b1, 1'b0,32'h0,  1'b1,32'h20, 1'b1,4'h3,32'h1234, 1'b1,1'b0,32'h0,    1'b0,1'b1,1'b1,32'h20, 1'b1,4'h3,32'h1234, 1'b0,1'b0};
        vecs[5]  = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1};
        vecs[6]  = '{1'b1, 1'b1,32'h30, 1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h30, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[7]  = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'hA5A5,     1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0};
        vecs[8]  = '{1'b1, 1'b1,32'h40, 1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h40, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[9]  = '{1'b1, 1'b1,32'h40, 1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b0,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h40, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[10] = '{1'b1, 1'b1,32'h40, 1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b0,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h40, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[11] = '{1'b1, 1'b1,32'h40, 1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b1,1'b0,32'h0,       1'b1,1'b0,1'b1,32'h40, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[12] = '{1'b1, 1'b0,32'h0,  1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b1,1'b1,32'h11,      1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0};
        vecs[13] = '{1'b1, 1'b0,32'h0,  1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b1,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h80, 1'b0,4'hF,32'h0, 1'b0,1'b0};
        vecs[14] = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'h22,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1};
        vecs[15] = '{1'b1, 1'b1,32'h50, 1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h50, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[16] = '{1'b0, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'h77,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[17] = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1,32'h99,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[18] = '{1'b1, 1'b1,32'h60, 1'b1,32'h70, 1'b1,4'hC,32'hCAFE, 1'b1,1'b0,32'h0,    1'b1,1'b0,1'b1,32'h60, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[19] = '{1'b1, 1'b1,32'h64, 1'b1,32'h70, 1'b1,4'hC,32'hCAFE, 1'b1,1'b1,32'h1,    1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0};
        vecs[20] = '{1'b1, 1'b1,32'h64, 1'b1,32'h70, 1'b1,4'hC,32'hCAFE, 1'b1,1'b0,32'h0,    1'b0,1'b1,1'b1,32'h70, 1'b1,4'hC,32'hCAFE, 1'b0,1'b0};
        vecs[21] = '{1'b1, 1'b1,32'h64, 1'b1,32'h74, 1'b0,4'hF,32'h0, 1'b1,1'b1,32'h2,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1};
        vecs[22] = '{1'b1, 1'b1,32'h64, 1'b1,32'h74, 1'b0,4'hF,32'h0, 1'b1,1'b0,32'h0,       1'b1,1'b0,1'b1,32'h64, 1'b0,4'h0,32'h0, 1'b0,1'b0};
        vecs[23] = '{1'b1, 1'b1,32'h68, 1'b1,32'h74, 1'b0,4'hF,32'h0, 1'b1,1'b1,32'h3,       1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b0};
        vecs[24] = '{1'b1, 1'b1,32'h68, 1'b1,32'h74, 1'b0,4'hF,32'h0, 1'b1,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h74, 1'b0,4'hF,32'h0, 1'b0,1'b0};
        vecs[25] = '{1'b1, 1'b0,32'h0,  1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b1,1'b1,32'h4,        1'b0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0, 1'b0,1'b1};

        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].rst, vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].da, vecs[k].dwe,
                  vecs[k].dbe, vecs[k].dwd, vecs[k].mrdy, vecs[k].mrv, vecs[k].mrd);
            #3;
            check($sformatf("v%0d_i_req_ready", k), 32'(i_req_ready), 32'(vecs[k].e_ir));
            check($sformatf("v%0d_d_req_ready", k), 32'(d_req_ready), 32'(vecs[k].e_dr));
            check($sformatf("v%0d_m_req_valid", k), 32'(m_req_valid), 32'(vecs[k].e_mv));
            check($sformatf("v%0d_i_rsp_valid", k), 32'(i_rsp_valid), 32'(vecs[k].e_irv));
            check($sformatf("v%0d_d_rsp_valid", k), 32'(d_rsp_valid), 32'(vecs[k].e_drv));
            if (vecs[k].e_mv) begin
                check($sformatf("v%0d_m_address", k), m_address, vecs[k].e_ma);
                check($sformatf("v%0d_m_write_enable", k), 32'(m_write_enable), 32'(vecs[k].e_mwe));
                check($sformatf("v%0d_m_byte_enable", k), 32'(m_byte_enable), 32'(vecs[k].e_mbe));
                check($sformatf("v%0d_m_write_data", k), m_write_data, vecs[k].e_mwd);
            end
            if (vecs[k].rst) begin
                check($sformatf("v%0d_i_rsp_data", k), i_rsp_data, vecs[k].mrd);
                check($sformatf("v%0d_d_rsp_data", k), d_rsp_data, vecs[k].mrd);
            end
            @(posedge clk); #1;
        end

        // Random traffic: requesters hold payload until accepted; memory stalls and
        // responds at random, and occasionally emits a stray response while idle.
        mb = 1'b0; mown = 0; mlast = 1; mheld = -1;
        ip = 1'b0; dp = 1'b0;
        ia_r = '0; da_r = '0; dwe_r = 1'b0; dbe_r = '0; dwd_r = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rr = (cyc >= 2) && ($urandom_range(99) != 0);
            if (!ip && $urandom_range(2) == 0) begin
                ip = 1'b1; ia_r = $urandom;
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp = 1'b1; da_r = $urandom; dwe_r = ($urandom_range(1) == 1);
                dbe_r = BW'($urandom); dwd_r = $urandom;
            end
            mrdy_r = ($urandom_range(9) < 7);
            mrv_r  = mb ? ($urandom_range(1) == 1) : ($urandom_range(4) == 0);
            mrd_r  = $urandom;
            drive(rr, ip, ia_r, dp, da_r, dwe_r, dbe_r, dwd_r, mrdy_r, mrv_r, mrd_r);
            #3;

            if (mheld >= 0) win = mheld;
            else if (ip && dp) win = (mlast == 1) ? 0 : 1;
            else win = dp ? 1 : 0;
            emv = rr && !mb && (ip || dp);
            ehs = emv && mrdy_r;

            check("rnd_i_req_ready", 32'(i_req_ready), 32'(ehs && win == 0));
            check("rnd_d_req_ready", 32'(d_req_ready), 32'(ehs && win == 1));
            check("rnd_m_req_valid", 32'(m_req_valid), 32'(emv));
            check("rnd_i_rsp_valid", 32'(i_rsp_valid), 32'(rr && mb && mrv_r && mown == 0));
            check("rnd_d_rsp_valid", 32'(d_rsp_valid), 32'(rr && mb && mrv_r && mown == 1));
            if (emv) begin
                check("rnd_m_address", m_address, (win == 1) ? da_r : ia_r);
                check("rnd_m_write_enable", 32'(m_write_enable), 32'(win == 1 && dwe_r));
                check("rnd_m_byte_enable", 32'(m_byte_enable), 32'((win == 1) ? dbe_r : 4'h0));
                check("rnd_m_write_data", m_write_data, (win == 1) ? dwd_r : 32'h0);
            end
            if (rr) begin
                check("rnd_i_rsp_data", i_rsp_data, mrd_r);
                check("rnd_d_rsp_data", d_rsp_data, mrd_r);
            end

            if (!rr) begin
                mb = 1'b0; mheld = -1; mlast = 1;
            end else if (!mb) begin
                if (ehs) begin
                    mb = 1'b1; mown = win; mlast = win; mheld = -1;
                    if (win == 0) ip = 1'b0;
                    else dp = 1'b0;
                end else if (emv) begin
                    mheld = win;
                end
            end else if (mrv_r) begin
                mb = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
